// File: rtl/weight_stream_writer.sv
// Buffered weight/line writer: a loader fills a small buffer, then on start the
// contents go out as a valid/ready stream with a last flag and an end-of-file pulse.
module weight_stream_writer #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  input  logic              start,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   ZERO_CNT = '0;
  localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [ADDR_W:0]     count_d, count_eff;
  logic                wr_accept, wr_drop, xfer;
  logic                out_valid_d, out_last_d, busy_d, done_d, overflow_d;
  logic [DATA_W-1:0]   out_data_d;

  assign wr_full   = (count == FULL_CNT);
  assign wr_accept = (state_q == S_IDLE) && wr_en && !wr_full;
  assign wr_drop   = (state_q == S_IDLE) && wr_en && wr_full;
  // A write coinciding with start is folded into the stream length.
  assign count_eff = wr_accept ? count + ONE_CNT : count;
  assign xfer      = out_valid && out_ready;
  assign ptr_inc   = ptr_q + ONE_PTR;

  // Buffer storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[count[ADDR_W-1:0]] <= wr_data;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_eff;
    ptr_d       = ptr_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_last_d  = out_last;
    overflow_d  = overflow | wr_drop;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          overflow_d = 1'b0;
          if (count_eff == ZERO_CNT) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_STREAM;
            ptr_d       = '0;
            out_valid_d = 1'b1;
            // Entry 0 may be the word being written this very cycle.
            out_data_d  = (count == ZERO_CNT) ? wr_data : mem[0];
            out_last_d  = (count_eff == ONE_CNT);
          end
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (out_last) begin
            state_d     = S_DONE;
            count_d     = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            ptr_d      = ptr_inc;
            out_data_d = mem[ptr_inc];
            out_last_d = ({1'b0, ptr_inc} == (count - ONE_CNT));
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = '0;
      end
      default: begin
        state_d     = S_IDLE;
        count_d     = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = '0;
      end
    endcase

    busy_d = (state_d == S_STREAM);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count     <= '0;
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count     <= count_d;
      ptr_q     <= ptr_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
      done      <= done_d;
      overflow  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_weight_stream_writer.sv
// Directed bench for weight_stream_writer: load, stream, stall, empty, overflow,
// interference and mid-stream reset scenarios with hand-computed expectations.
module tb_weight_stream_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_data;
  logic       wr_full;
  logic       start;
  logic       out_valid;
  logic [5:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [4:0] count;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;

  weight_stream_writer dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .start     (start),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] val);
    wr_en   = 1'b1;
    wr_data = val;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         pat [8] = '{1, 0, 0, 1, 0, 1, 1, 1};
    int         got;
    bit         fin;
    bit         stalled;
    logic [5:0] held;
    logic       held_last;

    rst = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_full", 32'(wr_full), 0);
    chk("rst_count", 32'(count), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic stream of three words with ready held high
    out_ready = 1'b1;
    load(6'd3); load(6'd17); load(6'd63);
    chk("t1_count", 32'(count), 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_v0", 32'(out_valid), 1);
    chk("t1_d0", 32'(out_data), 3);
    chk("t1_l0", 32'(out_last), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_d1", 32'(out_data), 17);
    chk("t1_l1", 32'(out_last), 0);
    tick();
    chk("t1_d2", 32'(out_data), 63);
    chk("t1_l2", 32'(out_last), 1);
    chk("t1_v2", 32'(out_valid), 1);
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_vend", 32'(out_valid), 0);
    chk("t1_lend", 32'(out_last), 0);
    chk("t1_bend", 32'(busy), 0);
    tick();
    chk("t1_done_off", 32'(done), 0);
    chk("t1_cnt0", 32'(count), 0);

    // Backpressure: words 1..5 under a toggling ready pattern
    for (int i = 1; i <= 5; i++) load(6'(i));
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    fin = 1'b0;
    for (int c = 0; c < 30 && !fin; c++) begin
      out_ready = (c < 8) ? (pat[c] != 0) : 1'b1;
      stalled   = out_valid && !out_ready;
      held      = out_data;
      held_last = out_last;
      if (out_valid && out_ready) begin
        chk("t2_data", 32'(out_data), 32'(got + 1));
        chk("t2_last", 32'(out_last), 32'(got == 4));
        got++;
      end
      tick();
      if (stalled) begin
        chk("t2_hold_d", 32'(out_data), 32'(held));
        chk("t2_hold_l", 32'(out_last), 32'(held_last));
        chk("t2_hold_v", 32'(out_valid), 1);
      end
      if (done) fin = 1'b1;
    end
    chk("t2_words", 32'(got), 5);
    chk("t2_fin", 32'(fin), 1);
    out_ready = 1'b1;
    tick();

    // Empty file
    chk("t3_cnt", 32'(count), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_done", 32'(done), 1);
    chk("t3_valid", 32'(out_valid), 0);
    chk("t3_busy", 32'(busy), 0);
    tick();
    chk("t3_done_off", 32'(done), 0);
    chk("t3_valid2", 32'(out_valid), 0);
    chk("t3_busy2", 32'(busy), 0);

    // Overflow: 17 writes into 16 entries, then stream all 16
    for (int i = 0; i < 16; i++) begin
      load(6'(i + 1));
      if (i == 14) chk("t4_notfull", 32'(wr_full), 0);
    end
    chk("t4_full", 32'(wr_full), 1);
    chk("t4_ovf0", 32'(overflow), 0);
    load(6'd63);
    chk("t4_ovf1", 32'(overflow), 1);
    chk("t4_cnt16", 32'(count), 16);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk("t4_valid", 32'(out_valid), 1);
      chk("t4_data", 32'(out_data), 32'(i + 1));
      chk("t4_last", 32'(out_last), 32'(i == 15));
      tick();
    end
    chk("t4_done", 32'(done), 1);
    tick();
    chk("t4_cnt0", 32'(count), 0);

    // Interference: wr_en and start during STREAM and DONE are ignored
    load(6'd10); load(6'd20); load(6'd30);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_d0", 32'(out_data), 10);
    wr_en = 1'b1; wr_data = 6'd55; start = 1'b1;
    tick();
    chk("t5_d1", 32'(out_data), 20);
    chk("t5_l1", 32'(out_last), 0);
    tick();
    chk("t5_d2", 32'(out_data), 30);
    chk("t5_l2", 32'(out_last), 1);
    tick();
    chk("t5_done", 32'(done), 1);
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_valid", 32'(out_valid), 0);
    chk("t5_ovf", 32'(overflow), 0);
    tick();
    chk("t5_cnt", 32'(count), 0);
    chk("t5_busy", 32'(busy), 0);

    // Reset mid-stream, then a single-word stream
    load(6'd7); load(6'd8); load(6'd9); load(6'd10);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_d0", 32'(out_data), 7);
    tick();
    chk("t6_d1", 32'(out_data), 8);
    tick();
    chk("t6_d2", 32'(out_data), 9);
    rst = 1'b0;
    #2;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_data", 32'(out_data), 0);
    chk("t6_rst_last", 32'(out_last), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_cnt", 32'(count), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    load(6'd42);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_v", 32'(out_valid), 1);
    chk("t6_d", 32'(out_data), 42);
    chk("t6_l", 32'(out_last), 1);
    tick();
    chk("t6_done", 32'(done), 1);
    chk("t6_vend", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_stream_writer.md
Name: weight_stream_writer

Overview:
- Producer end of the weight/input-line stream that the CatRecognizer file-reading benches consume.
- A loader fills an internal buffer one value at a time. On `start`, the block emits the buffer in order as a valid/ready stream, flags the final word with `out_last`, and pulses `done` as the end-of-file marker.
- It sits between weight-loading logic and any line-by-line consumer: a neuron datapath, or a bench monitor that dumps to text.

Parameters:
- DATA_W, 6: width of each stream word; matches the 6-bit captured line value.
- DEPTH, 16: number of buffer entries; must be a power of two, at least 2.
- ADDR_W, 4: log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- wr_en  in  1  load strobe; accepted only in IDLE and when not full.
- wr_data  in  DATA_W  value to append to the buffer.
- wr_full  out  1  high when count == DEPTH.
- start  in  1  begins streaming; sampled only in IDLE.
- out_valid  out  DATA_W-independent 1  stream word valid.
- out_data  out  DATA_W  stream word.
- out_last  out  1  high with out_valid on the final word.
- out_ready  in  1  consumer accepts the word this cycle.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle end-of-stream pulse.
- count  out  ADDR_W+1  number of entries currently loaded.
- overflow  out  1  sticky; a write was dropped.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, count=0, read pointer=0.
  - All outputs 0: out_valid, out_data, out_last, busy, done, overflow.
  - wr_full is 0.
  - Buffer contents are don't-care.
- States: IDLE, STREAM, DONE.
- IDLE, loading:
  - wr_en with count<DEPTH: writes wr_data at index count; count increments next edge.
  - wr_en with count==DEPTH: data dropped; overflow set to 1.
  - wr_en outside IDLE: ignored; does not set overflow.
- IDLE to STREAM: start=1 and count>0.
  - At the next edge: read pointer=0, out_valid=1, out_data=entry0, out_last=(count==1), busy=1.
  - Latency from start to the first valid word is 1 cycle.
  - overflow clears on that same edge.
- IDLE to DONE: start=1 and count==0 (empty file). No valid word is ever driven.
- Simultaneous start and wr_en in IDLE: the write is applied first.
  - The stream includes the new word, and its length is the updated count.
  - If count==DEPTH, the write is dropped, overflow sets, then is cleared by the start.
- STREAM, handshake:
  - A word transfers on an edge where out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0: out_data and out_last are held stable, and out_valid stays high.
  - On a transfer of a non-last word: pointer+1; next word presented the following cycle.
  - Throughput is 1 word/cycle when out_ready is held high; there are no bubbles.
  - out_ready while out_valid=0 has no effect.
- STREAM to DONE: on the transfer with out_last=1.
  - Next cycle: out_valid=0, out_last=0, busy=0, done=1.
- DONE: lasts exactly 1 cycle.
  - count resets to 0, so the buffer is consumed.
  - Then the block returns to IDLE.
  - start during DONE is ignored.
- start during STREAM: ignored.
- wr_full is combinational from count.
- out_data is registered from the buffer; there is no combinational path from out_ready to out_data.
- Reset mid-stream: immediate abort. All outputs return to reset values, and count=0, so a partial stream is discarded.
- Pointer width is ADDR_W. It never wraps within a stream because streaming stops at index count-1.
- No arithmetic is applied to data words; they are passed bit-exact.

Test Plan:
- Load 3, 17, 63, start, out_ready=1 held:
  - out_valid high for 3 consecutive cycles with data 3, 17, 63, starting 1 cycle after start.
  - out_last only on 63.
  - done pulses the cycle after.
  - count returns to 0.
- Load 5 words 1..5, toggle out_ready 1,0,0,1,0,1,1,1:
  - Each word is held stable while stalled.
  - The sequence received is exactly 1..5, with no duplicates or drops.
- start with count=0 -> done=1 next cycle, out_valid never asserted, busy stays 0.
- Overflow:
  - Write 17 words with DEPTH=16 -> wr_full=1 after the 16th, overflow=1 after the 17th, count=16.
  - Then start -> overflow clears and 16 words stream, with word 16 flagged last.
- Interference: wr_en and start pulsed mid-stream -> ignored; stream length and content unchanged.
- Reset mid-stream: load 4 words, start, drop rst after 2 transfers -> all outputs 0 immediately and count=0.
  - After release, a new load of value 42 and start -> single word 42 with out_last=1.
